vermicom_tx_arbiter: RTL and testbench

- Bus master that owns one Vermicom UART and shares its transmitter between NUM_REQ byte-stream requesters.
- Arbitration is round-robin.
- After reset it configures the UART (division, control) once. It then sequences every byte as: write DATA, poll STATUS for tx_event_flag, clear the flag.
- Sits between on-chip byte producers (debug console, logger, monitor) and the Vermicom bus slave port.

---
 rtl/vermicom_tx_arbiter_pkg.sv | 41 ++++
 rtl/vermicom_tx_arbiter_if.sv | 29 ++
 rtl/vermicom_tx_arbiter_rr_arbiter.sv | 42 ++++
 rtl/vermicom_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vermicom_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vermicom_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// vermicom_tx_arbiter_pkg
// Shared definitions for the Vermicom transmit arbiter:
//   - local (word) addresses of the Vermicom register block
//   - status_reg_t, the layout of the Vermicom STATUS register
//   - arb_state_t, the arbiter sequencing states
//   - TX_FLAG_CLEAR, the STATUS write value that clears only tx_event_flag
//   - reg_address(), byte address of a register given the block base
// ----------------------------------------------------------------------------
package vermicom_tx_arbiter_pkg;

   // Word addresses inside the Vermicom register block.
   localparam logic [1:0] CONTROL_ADDRESS  = 2'd0;
   localparam logic [1:0] STATUS_ADDRESS   = 2'd1;
   localparam logic [1:0] DIVISION_ADDRESS = 2'd2;
   localparam logic [1:0] DATA_ADDRESS     = 2'd3;

   // STATUS register; event flags are write-one-to-clear.
   typedef struct packed {
      logic [29:0] reserved;
      logic        rx_event_flag;
      logic        tx_event_flag;
   } status_reg_t;

   // Doubles as the tx flag test mask when polling STATUS.
   localparam status_reg_t TX_FLAG_CLEAR = '{reserved: '0, rx_event_flag: 1'b0, tx_event_flag: 1'b1};

   typedef enum logic [2:0] {
      INIT_DIV,
      INIT_CTRL,
      IDLE,
      WRITE_DATA,
      POLL,
      CLEAR
   } arb_state_t;

   function automatic logic [31:0] reg_address(input logic [31:0] base, input logic [1:0] loc);
      return base + {28'd0, loc, 2'b00};
   endfunction

endpackage

// File: rtl/vermicom_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// vermicom_tx_arbiter_if
// Simple valid/ready register bus between the arbiter (master) and the
// Vermicom slave port.
//   bus_valid    master request valid
//   bus_address  byte address
//   bus_wstrobe  byte write strobes, 0 means read
//   bus_wdata    write data
//   bus_rdata    read data, meaningful when bus_valid && bus_ready
//   bus_ready    slave completion
// ----------------------------------------------------------------------------
interface vermicom_tx_arbiter_if;
   logic        bus_valid;
   logic [31:0] bus_address;
   logic [3:0]  bus_wstrobe;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   modport master (
      output bus_valid, bus_address, bus_wstrobe, bus_wdata,
      input  bus_rdata, bus_ready
   );

   modport slave (
      input  bus_valid, bus_address, bus_wstrobe, bus_wdata,
      output bus_rdata, bus_ready
   );
endinterface

// File: rtl/vermicom_tx_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// vermicom_tx_arbiter_rr_arbiter
// Combinational round-robin pick: the first set request strictly after
// 'last', wrapping modulo N. The last-grant register lives in the parent.
//   req          request vector
//   last         index of the previously granted requester
//   enable       arbitration allowed this cycle
//   grant        chosen index (equals 'last' when nothing is granted)
//   grant_valid  a request was chosen
// ----------------------------------------------------------------------------
module vermicom_tx_arbiter_rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   input  logic         enable,
   output logic [W-1:0] grant,
   output logic         grant_valid
);

   always_comb begin
      int idx;
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      idx         = 0;
      grant       = last;
      grant_valid = 1'b0;
      if (enable) begin
         // Scan from the farthest candidate to the nearest; the nearest set
         // request after 'last' is written last and therefore wins.
         for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx[W-1:0]]) begin
               grant       = idx[W-1:0];
               grant_valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vermicom_tx_arbiter.sv
// ----------------------------------------------------------------------------
// vermicom_tx_arbiter
// Owns one Vermicom UART and shares its transmitter between NUM_REQ byte
// producers using round-robin arbitration. After reset it writes DIVISION
// and CONTROL once, then for each byte: write DATA, poll STATUS until
// tx_event_flag is set, clear that flag.
//   clk        system clock
//   reset      asynchronous active-high reset
//   req_valid  per-requester byte pending
//   req_data   per-requester byte, byte i at [8*i+:8]
//   req_ready  one-cycle pulse: byte i accepted by the UART
//   bus        master side of the Vermicom register bus
//   busy       high from grant until the flag clear completes
//   owner      index of the current or last granted requester
// ----------------------------------------------------------------------------
module vermicom_tx_arbiter
   import vermicom_tx_arbiter_pkg::*;
#(
   parameter  int          NUM_REQ      = 4,
   parameter  logic [31:0] BASE_ADDRESS = 32'h8000_0000,
   parameter  int          DIVISION     = 868,
   localparam int          OW           = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*8-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   vermicom_tx_arbiter_if.master  bus,
   output logic                   busy,
   output logic [OW-1:0]          owner
);

   localparam logic [31:0] CTRL_ADDR   = reg_address(BASE_ADDRESS, CONTROL_ADDRESS);
   localparam logic [31:0] STATUS_ADDR = reg_address(BASE_ADDRESS, STATUS_ADDRESS);
   localparam logic [31:0] DIV_ADDR    = reg_address(BASE_ADDRESS, DIVISION_ADDRESS);
   localparam logic [31:0] DATA_ADDR   = reg_address(BASE_ADDRESS, DATA_ADDRESS);
   localparam logic [31:0] TX_MASK     = 32'(TX_FLAG_CLEAR);

   arb_state_t           state, state_nxt;
   logic                 valid_q, valid_nxt;
   logic [31:0]          address_q, address_nxt;
   logic [3:0]           wstrobe_q, wstrobe_nxt;
   logic [31:0]          wdata_q, wdata_nxt;
   logic [NUM_REQ-1:0]   req_ready_nxt;
   logic                 busy_nxt;
   logic [OW-1:0]        owner_nxt;

   logic                 done;
   logic                 tx_flag_set;
   logic [OW-1:0]        grant;
   logic                 grant_valid;

   assign bus.bus_valid   = valid_q;
   assign bus.bus_address = address_q;
   assign bus.bus_wstrobe = wstrobe_q;
   assign bus.bus_wdata   = wdata_q;

   assign done = valid_q && bus.bus_ready;
   // Only the tx flag matters; rx_event_flag is masked off and never cleared.
   assign tx_flag_set = (bus.bus_rdata & TX_MASK) != '0;

   vermicom_tx_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req         (req_valid),
      .last        (owner),
      .enable      (state == IDLE),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      if (reset) begin
         state     <= INIT_DIV;
         valid_q   <= 1'b0;
         address_q <= '0;
         wstrobe_q <= '0;
         wdata_q   <= '0;
         req_ready <= '0;
         busy      <= 1'b0;
         owner     <= OW'(NUM_REQ - 1);
      end else begin
         state     <= state_nxt;
         valid_q   <= valid_nxt;
         address_q <= address_nxt;
         wstrobe_q <= wstrobe_nxt;
         wdata_q   <= wdata_nxt;
         req_ready <= req_ready_nxt;
         busy      <= busy_nxt;
         owner     <= owner_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT_DIV:   if (done)                state_nxt = INIT_CTRL;
         INIT_CTRL:  if (done)                state_nxt = IDLE;
         IDLE:       if (grant_valid)         state_nxt = WRITE_DATA;
         WRITE_DATA: if (done)                state_nxt = POLL;
         POLL:       if (done && tx_flag_set) state_nxt = CLEAR;
         CLEAR:      if (done)                state_nxt = IDLE;
         default:                             state_nxt = INIT_DIV;
      endcase
   end

   // Next output values. Bus fields hold by default, which keeps them
   // stable while the slave stalls and re-issues the STATUS read in POLL.
   always_comb begin
      valid_nxt     = valid_q;
      address_nxt   = address_q;
      wstrobe_nxt   = wstrobe_q;
      wdata_nxt     = wdata_q;
      req_ready_nxt = '0;
      busy_nxt      = busy;
      owner_nxt     = owner;
      unique case (state)
         INIT_DIV: begin
            if (done) begin
               // DIVISION accepted: CONTROL write on the same edge, IRQs off.
               valid_nxt   = 1'b1;
               address_nxt = CTRL_ADDR;
               wstrobe_nxt = 4'hF;
               wdata_nxt   = '0;
            end else if (!valid_q) begin
               // First cycle out of reset.
               valid_nxt   = 1'b1;
               address_nxt = DIV_ADDR;
               wstrobe_nxt = 4'hF;
               wdata_nxt   = 32'(DIVISION);
            end
         end
         INIT_CTRL: begin
            if (done) valid_nxt = 1'b0;
         end
         IDLE: begin
            if (grant_valid) begin
               owner_nxt   = grant;
               busy_nxt    = 1'b1;
               valid_nxt   = 1'b1;
               address_nxt = DATA_ADDR;
               wstrobe_nxt = 4'h1;
               // Byte is latched here, so a later drop of req_valid is harmless.
               wdata_nxt   = {24'd0, req_data[8*grant +: 8]};
            end
         end
         WRITE_DATA: begin
            if (done) begin
               req_ready_nxt[owner] = 1'b1;
               address_nxt          = STATUS_ADDR;
               wstrobe_nxt          = 4'h0;
               wdata_nxt            = '0;
            end
         end
         POLL: begin
            if (done && tx_flag_set) begin
               address_nxt = STATUS_ADDR;
               wstrobe_nxt = 4'hF;
               wdata_nxt   = TX_MASK;
            end
         end
         CLEAR: begin
            if (done) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_vermicom_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vermicom_tx_arbiter
// Bench for vermicom_tx_arbiter with a behavioural Vermicom slave (optional
// ready wait states, tx flag raised a programmable time after a DATA write,
// write-one-to-clear flags). Expected bus writes and req_ready pulses are
// queued when stimulus is applied and popped when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_vermicom_tx_arbiter;

   localparam int          NR     = 4;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'd4;
   localparam logic [31:0] A_DIV  = BASE + 32'd8;
   localparam logic [31:0] A_DATA = BASE + 32'd12;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } txn_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*8-1:0] req_data = '0;
   logic [NR-1:0]   req_ready;
   logic            busy;
   logic [1:0]      owner;

   vermicom_tx_arbiter_if bus_if ();

   vermicom_tx_arbiter #(
      .NUM_REQ      (NR),
      .BASE_ADDRESS (BASE),
      .DIVISION     (868)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .bus       (bus_if.master),
      .busy      (busy),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // ---------------- Vermicom slave model ----------------
   int   wait_n   = 0;
   int   wcnt     = 0;
   int   tx_delay = 10;
   int   tx_cnt   = 0;
   logic tx_busy, tx_flag, rx_flag;
   logic rx_set = 1'b0;

   assign bus_if.bus_ready = bus_if.bus_valid && (wcnt >= wait_n);
   assign bus_if.bus_rdata = {30'd0, rx_flag, tx_flag};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt    <= 0;
         tx_cnt  <= 0;
         tx_busy <= 1'b0;
         tx_flag <= 1'b0;
         rx_flag <= 1'b0;
      end else begin
         if (rx_set) rx_flag <= 1'b1;
         if (bus_if.bus_valid && !bus_if.bus_ready) wcnt <= wcnt + 1;
         else wcnt <= 0;
         if (tx_busy) begin
            if (tx_cnt <= 1) begin
               tx_busy <= 1'b0;
               tx_flag <= 1'b1;
            end else begin
               tx_cnt <= tx_cnt - 1;
            end
         end
         if (bus_if.bus_valid && bus_if.bus_ready && bus_if.bus_wstrobe != 4'h0) begin
            if (bus_if.bus_address == A_DATA) begin
               tx_busy <= 1'b1;
               tx_cnt  <= tx_delay;
            end
            if (bus_if.bus_address == A_STAT) begin
               if (bus_if.bus_wdata[0]) tx_flag <= 1'b0;
               if (bus_if.bus_wdata[1]) rx_flag <= 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard and monitor ----------------
   txn_t exp_q[$];
   int   rdy_q[$];
   int   cyc      = 0;
   int   poll_cnt = 0;
   int   div_cyc  = 0;
   int   ctrl_cyc = 0;
   logic hold_act = 1'b0;
   txn_t held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_init();
      exp_q.push_back('{addr: A_DIV,  strb: 4'hF, data: 32'd868});
      exp_q.push_back('{addr: A_CTRL, strb: 4'hF, data: 32'd0});
   endtask

   task automatic exp_byte(input int idx, input logic [7:0] b);
      exp_q.push_back('{addr: A_DATA, strb: 4'h1, data: {24'd0, b}});
      exp_q.push_back('{addr: A_STAT, strb: 4'hF, data: 32'h1});
      rdy_q.push_back(idx);
   endtask

   always @(negedge clk) begin
      txn_t cur;
      txn_t e;
      int   i;
      if (reset) begin
         hold_act = 1'b0;
      end else begin
         cur = '{addr: bus_if.bus_address, strb: bus_if.bus_wstrobe, data: bus_if.bus_wdata};
         if (req_ready != '0) begin
            if (rdy_q.size() == 0) begin
               check("ready_unexpected", 32'(req_ready), 32'd0);
            end else begin
               i = rdy_q.pop_front();
               check("ready_vec", 32'(req_ready), 32'd1 << i);
               check("ready_owner", 32'(owner), i);
               check("ready_busy", 32'(busy), 32'd1);
            end
         end
         if (bus_if.bus_valid) begin
            if (hold_act) begin
               check("hold_addr", cur.addr, held.addr);
               check("hold_strb", 32'(cur.strb), 32'(held.strb));
               check("hold_data", cur.data, held.data);
            end
            if (!bus_if.bus_ready) begin
               hold_act = 1'b1;
               held     = cur;
            end else begin
               hold_act = 1'b0;
               if (cur.strb == 4'h0) begin
                  check("read_addr", cur.addr, A_STAT);
                  poll_cnt++;
               end else if (exp_q.size() == 0) begin
                  check("extra_write_addr", cur.addr, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", cur.addr, e.addr);
                  check("wr_strb", 32'(cur.strb), 32'(e.strb));
                  check("wr_data", cur.data, e.data);
                  if (cur.addr == A_DIV)  div_cyc  = cyc;
                  if (cur.addr == A_CTRL) ctrl_cyc = cyc;
               end
            end
         end else begin
            hold_act = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_idle(input string tag, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && rdy_q.size() == 0 && !busy && !bus_if.bus_valid) break;
      end
      check({tag, "_pending"}, exp_q.size() + rdy_q.size(), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(bus_if.bus_valid), 32'd0);
   endtask

   task automatic wait_ready(input string tag, input int idx, input int budget);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (req_ready[idx]) seen = 1'b1;
      end
      check({tag, "_ready_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus_if.bus_valid), 32'd0);
      check({tag, "_addr"}, bus_if.bus_address, 32'd0);
      check({tag, "_strb"}, 32'(bus_if.bus_wstrobe), 32'd0);
      check({tag, "_wdata"}, bus_if.bus_wdata, 32'd0);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_owner"}, 32'(owner), NR - 1);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      exp_q.delete();
      rdy_q.delete();
      @(negedge clk);
      exp_init();
      reset = 1'b0;
      wait_idle(tag, 50);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int p0;

      // 1: reset values, then DIVISION and CONTROL in consecutive cycles.
      repeat (3) @(negedge clk);
      check_reset_outputs("t1_rst");
      exp_init();
      reset = 1'b0;
      wait_idle("t1", 50);
      check("t1_consecutive", ctrl_cyc - div_cyc, 32'd1);

      // 2: single byte from requester 2 with a realistic frame time.
      tx_delay = 10 * 869;
      p0 = poll_cnt;
      exp_byte(2, 8'h41);
      req_data[23:16] = 8'h41;
      req_valid[2]    = 1'b1;
      wait_ready("t2", 2, 50);
      req_valid[2] = 1'b0;
      wait_idle("t2", 10000);
      check("t2_poll_span_ok", 32'((poll_cnt - p0) >= 8680 && (poll_cnt - p0) <= 8700), 32'd1);

      // 3: all four valid continuously -> strict rotation starting at 0.
      do_reset("t3_init");
      tx_delay = 10;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 8; k++) exp_byte(k % NR, 8'h10 + 8'(k % NR));
      req_valid = '1;
      for (int k = 0; k < 8; k++) wait_ready("t3", k % NR, 100);
      req_valid = '0;
      wait_idle("t3", 200);

      // 4: slave inserts 3 wait states on every transaction.
      wait_n = 3;
      exp_byte(1, 8'h7E);
      req_data[15:8] = 8'h7E;
      req_valid[1]   = 1'b1;
      wait_ready("t4", 1, 100);
      req_valid[1] = 1'b0;
      wait_idle("t4", 400);
      wait_n = 0;

      // 6: rx flag set while tx flag clear -> keep polling, clear only tx.
      rx_set = 1'b1;
      @(negedge clk);
      rx_set = 1'b0;
      tx_delay = 15;
      p0 = poll_cnt;
      exp_byte(0, 8'h33);
      req_data[7:0] = 8'h33;
      req_valid[0]  = 1'b1;
      wait_ready("t6", 0, 50);
      req_valid[0] = 1'b0;
      wait_idle("t6", 200);
      check("t6_polls_gt_1", 32'((poll_cnt - p0) > 1), 32'd1);
      check("t6_rx_kept", 32'(rx_flag), 32'd1);

      // 5: reset during POLL of the second byte; pending requester re-granted.
      do_reset("t5_init");
      tx_delay = 40;
      req_data[15:8]  = 8'h51;
      req_data[31:24] = 8'h53;
      exp_byte(1, 8'h51);
      exp_byte(3, 8'h53);
      req_valid = 4'b1010;
      wait_ready("t5a", 1, 100);
      req_valid[1] = 1'b0;
      wait_ready("t5b", 3, 200);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("t5_async");
      exp_q.delete();
      rdy_q.delete();
      exp_init();
      exp_byte(3, 8'h53);
      @(negedge clk);
      reset = 1'b0;
      wait_ready("t5c", 3, 100);
      req_valid = '0;
      wait_idle("t5", 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
